fc_addr_demux: RTL and testbench

- Parametrised N-way address demultiplexer between one core-side TCDM-style master port (req/gnt/r_valid) and N_SLAVES slave ports. Generalises the fixed two-way L2/SCM split on the FC core instruction and data paths.
- Adds address-region decode, bounded outstanding-transaction tracking and in-order response steering.
- Unmapped accesses get a local error response, and the offending address is captured.

---
 rtl/fc_demux_pkg.sv | 29 ++
 rtl/fc_addr_decoder.sv | 28 ++
 rtl/fc_addr_demux.sv | 163 ++++++++++++++++
 tb/tb_fc_addr_demux.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_demux_pkg.sv
// Shared types, widths and default address map for the FC address demultiplexer.
// Region bounds are stored at the widest supported address width so one typedef serves every instance.
package fc_demux_pkg;

  localparam int MAX_SLAVES     = 8;
  localparam int MAX_ADDR_WIDTH = 64;
  localparam int TGT_WIDTH      = $clog2(MAX_SLAVES + 1);
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hBADACCE5;

  typedef logic [TGT_WIDTH-1:0]      tgt_idx_t;
  typedef logic [MAX_ADDR_WIDTH-1:0] region_addr_t;
  typedef region_addr_t [MAX_SLAVES-1:0] region_arr_t;

  // Default map: slave 0 is the SCM window, slave 1 the L2 window.
  localparam region_arr_t DEF_REGION_START = {
    {(MAX_SLAVES - 2){64'h0}}, 64'h0000_0000_1C00_8000, 64'h0000_0000_1C00_0000
  };
  localparam region_arr_t DEF_REGION_END = {
    {(MAX_SLAVES - 2){64'h0}}, 64'h0000_0000_1C08_0000, 64'h0000_0000_1C00_8000
  };

  function automatic logic in_region(region_addr_t addr, region_addr_t lo, region_addr_t hi);
    return (addr >= lo) && (addr < hi);
  endfunction

endpackage

// File: rtl/fc_addr_decoder.sv
// Combinational region decoder: returns the lowest matching slave index,
// or N_SLAVES when the address falls outside every region.
module fc_addr_decoder
  import fc_demux_pkg::*;
#(
  parameter int          N_SLAVES     = 2,
  parameter int          ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter region_arr_t REGION_START = DEF_REGION_START,
  parameter region_arr_t REGION_END   = DEF_REGION_END
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output tgt_idx_t              tgt_o
);

  region_addr_t addr_ext;

  // Walk downwards so the lowest-index matching region is the last one written.
  always_comb begin
    addr_ext = region_addr_t'(addr_i);
    tgt_o    = tgt_idx_t'(N_SLAVES);
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (in_region(addr_ext, REGION_START[i], REGION_END[i])) begin
        tgt_o = tgt_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/fc_addr_demux.sv
// N-way address demultiplexer for the FC core master port.
// Responses stay in order because only one target may hold outstanding transactions at a time.
module fc_addr_demux
  import fc_demux_pkg::*;
#(
  parameter int                    N_SLAVES        = 2,
  parameter int                    ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter region_arr_t           REGION_START    = DEF_REGION_START,
  parameter region_arr_t           REGION_END      = DEF_REGION_END,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = DATA_WIDTH'(ERR_RDATA_DEF)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                m_req_i,
  input  logic [ADDR_WIDTH-1:0]               m_add_i,
  input  logic                                m_wen_i,
  input  logic [DATA_WIDTH-1:0]               m_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]             m_be_i,
  output logic                                m_gnt_o,
  output logic                                m_r_valid_o,
  output logic [DATA_WIDTH-1:0]               m_r_rdata_o,
  output logic                                m_r_opc_o,
  output logic [N_SLAVES-1:0]                 s_req_o,
  output logic [ADDR_WIDTH-1:0]               s_add_o,
  output logic                                s_wen_o,
  output logic [DATA_WIDTH-1:0]               s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]             s_be_o,
  input  logic [N_SLAVES-1:0]                 s_gnt_i,
  input  logic [N_SLAVES-1:0]                 s_r_valid_i,
  input  logic [N_SLAVES-1:0]                 s_r_opc_i,
  input  logic [N_SLAVES-1:0][DATA_WIDTH-1:0] s_r_rdata_i,
  output logic                                dec_err_o,
  output logic [ADDR_WIDTH-1:0]               dec_err_addr_o,
  output logic                                spurious_o
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam tgt_idx_t         ERR_TGT = tgt_idx_t'(N_SLAVES);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  tgt_idx_t              last_tgt_q, last_tgt_d;
  logic                  err_pend_q, err_pend_d;
  logic                  spurious_q, spurious_d;
  logic [ADDR_WIDTH-1:0] dec_err_addr_q, dec_err_addr_d;

  tgt_idx_t              tgt;
  logic                  tgt_is_err;
  logic                  issue_ok;
  logic                  tgt_gnt;
  logic                  grant;
  logic [N_SLAVES-1:0]   s_req;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_opc;
  logic                  spur_hit;

  fc_addr_decoder #(
    .N_SLAVES     (N_SLAVES),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .REGION_START (REGION_START),
    .REGION_END   (REGION_END)
  ) u_decoder (
    .addr_i (m_add_i),
    .tgt_o  (tgt)
  );

  // A new target is only accepted once everything issued to the old one has answered.
  always_comb begin
    tgt_is_err = (tgt == ERR_TGT);
    issue_ok   = m_req_i && (cnt_q < CNT_MAX) && ((cnt_q == '0) || (tgt == last_tgt_q));
    tgt_gnt    = 1'b0;
    s_req      = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (tgt == tgt_idx_t'(i)) begin
        s_req[i] = issue_ok;
        tgt_gnt  = s_gnt_i[i];
      end
    end
    grant = issue_ok && (tgt_is_err || tgt_gnt);
  end

  // Only the current target may answer; decode errors answer from the local pending flag.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_opc   = 1'b0;
    if (cnt_q != '0) begin
      if (last_tgt_q == ERR_TGT) begin
        if (err_pend_q) begin
          rsp_valid = 1'b1;
          rsp_rdata = ERR_RDATA;
          rsp_opc   = 1'b1;
        end
      end else begin
        for (int i = 0; i < N_SLAVES; i++) begin
          if ((last_tgt_q == tgt_idx_t'(i)) && s_r_valid_i[i]) begin
            rsp_valid = 1'b1;
            rsp_rdata = s_r_rdata_i[i];
            rsp_opc   = s_r_opc_i[i];
          end
        end
      end
    end
  end

  always_comb begin
    spur_hit = 1'b0;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (s_r_valid_i[j] && ((cnt_q == '0) || (last_tgt_q != tgt_idx_t'(j)))) begin
        spur_hit = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (grant && !rsp_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!grant && rsp_valid) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    last_tgt_d     = grant ? tgt : last_tgt_q;
    err_pend_d     = grant && tgt_is_err;
    spurious_d     = spurious_q || spur_hit;
    dec_err_addr_d = (grant && tgt_is_err) ? m_add_i : dec_err_addr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q          <= '0;
      last_tgt_q     <= '0;
      err_pend_q     <= 1'b0;
      spurious_q     <= 1'b0;
      dec_err_addr_q <= '0;
    end else begin
      cnt_q          <= cnt_d;
      last_tgt_q     <= last_tgt_d;
      err_pend_q     <= err_pend_d;
      spurious_q     <= spurious_d;
      dec_err_addr_q <= dec_err_addr_d;
    end
  end

  // Combinational outputs are forced low during reset so nothing leaks out while flops clear.
  always_comb begin
    m_gnt_o        = grant && !rst_i;
    s_req_o        = rst_i ? '0 : s_req;
    s_add_o        = rst_i ? '0 : m_add_i;
    s_wen_o        = m_wen_i && !rst_i;
    s_wdata_o      = rst_i ? '0 : m_wdata_i;
    s_be_o         = rst_i ? '0 : m_be_i;
    m_r_valid_o    = rsp_valid && !rst_i;
    m_r_rdata_o    = rst_i ? '0 : rsp_rdata;
    m_r_opc_o      = rsp_opc && !rst_i;
    dec_err_o      = grant && tgt_is_err && !rst_i;
    dec_err_addr_o = dec_err_addr_q;
    spurious_o     = spurious_q;
  end

endmodule

// File: tb/tb_fc_addr_demux.sv
// Directed bench for fc_addr_demux: two modelled slaves, a response scoreboard and a monitor.
// Slave i answers with rdata = addr + (i+1)*0x1000_0000 and opc set when addr[3:0] == 8.
module tb_fc_addr_demux;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              m_req_i;
  logic [31:0]       m_add_i;
  logic              m_wen_i;
  logic [31:0]       m_wdata_i;
  logic [3:0]        m_be_i;
  logic              m_gnt_o;
  logic              m_r_valid_o;
  logic [31:0]       m_r_rdata_o;
  logic              m_r_opc_o;
  logic [1:0]        s_req_o;
  logic [31:0]       s_add_o;
  logic              s_wen_o;
  logic [31:0]       s_wdata_o;
  logic [3:0]        s_be_o;
  logic [1:0]        s_gnt_i;
  logic [1:0]        s_r_valid_i;
  logic [1:0]        s_r_opc_i;
  logic [1:0][31:0]  s_r_rdata_i;
  logic              dec_err_o;
  logic [31:0]       dec_err_addr_o;
  logic              spurious_o;

  always #5 clk_i = ~clk_i;

  fc_addr_demux #(
    .N_SLAVES        (2),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .m_req_i        (m_req_i),
    .m_add_i        (m_add_i),
    .m_wen_i        (m_wen_i),
    .m_wdata_i      (m_wdata_i),
    .m_be_i         (m_be_i),
    .m_gnt_o        (m_gnt_o),
    .m_r_valid_o    (m_r_valid_o),
    .m_r_rdata_o    (m_r_rdata_o),
    .m_r_opc_o      (m_r_opc_o),
    .s_req_o        (s_req_o),
    .s_add_o        (s_add_o),
    .s_wen_o        (s_wen_o),
    .s_wdata_o      (s_wdata_o),
    .s_be_o         (s_be_o),
    .s_gnt_i        (s_gnt_i),
    .s_r_valid_i    (s_r_valid_i),
    .s_r_opc_i      (s_r_opc_i),
    .s_r_rdata_i    (s_r_rdata_i),
    .dec_err_o      (dec_err_o),
    .dec_err_addr_o (dec_err_addr_o),
    .spurious_o     (spurious_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        opc;
  } exp_t;

  typedef struct {
    int          ts;
    logic [31:0] data;
    logic        opc;
  } sreq_t;

  exp_t  exp_q[$];
  sreq_t sq0[$];
  sreq_t sq1[$];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [1:0] hold = 2'b00;
  logic [1:0] spur_inj = 2'b00;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave model: accepts on req&gnt, answers in order two cycles later unless held.
  initial begin
    s_gnt_i     = 2'b11;
    s_r_valid_i = 2'b00;
    s_r_opc_i   = 2'b00;
    s_r_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (s_r_valid_i[0] && !spur_inj[0] && sq0.size() > 0) void'(sq0.pop_front());
      if (s_r_valid_i[1] && !spur_inj[1] && sq1.size() > 0) void'(sq1.pop_front());
      if (s_req_o[0] && s_gnt_i[0])
        sq0.push_back('{ts: cyc, data: s_add_o + 32'h1000_0000, opc: (s_add_o[3:0] == 4'h8)});
      if (s_req_o[1] && s_gnt_i[1])
        sq1.push_back('{ts: cyc, data: s_add_o + 32'h2000_0000, opc: (s_add_o[3:0] == 4'h8)});
      @(posedge clk_i);
      #1;
      s_r_valid_i = 2'b00;
      s_r_opc_i   = 2'b00;
      s_r_rdata_i = '0;
      if (sq0.size() > 0 && cyc >= sq0[0].ts + 2 && !hold[0]) begin
        s_r_valid_i[0] = 1'b1;
        s_r_rdata_i[0] = sq0[0].data;
        s_r_opc_i[0]   = sq0[0].opc;
      end
      if (sq1.size() > 0 && cyc >= sq1[0].ts + 2 && !hold[1]) begin
        s_r_valid_i[1] = 1'b1;
        s_r_rdata_i[1] = sq1[0].data;
        s_r_opc_i[1]   = sq1[0].opc;
      end
      if (spur_inj[0]) begin
        s_r_valid_i[0] = 1'b1;
        s_r_rdata_i[0] = 32'hDEAD_0000;
      end
      if (spur_inj[1]) begin
        s_r_valid_i[1] = 1'b1;
        s_r_rdata_i[1] = 32'hDEAD_0001;
      end
    end
  end

  // Monitor: every master response must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk_i);
      if (m_r_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: actual rdata=%0h opc=%0b required no response",
                   m_r_rdata_o, m_r_opc_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("rsp_rdata", 96'(m_r_rdata_o), 96'(e.rdata));
          check_output("rsp_opc", 96'(m_r_opc_o), 96'(e.opc));
        end
      end else begin
        check_output("idle_rsp_zero", 96'({m_r_rdata_o, m_r_opc_o}), 96'(0));
      end
    end
  end

  // Drives one request until granted; checks steering and payload and queues the expected response.
  task automatic apply_stimulus(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [1:0] exp_sreq,
                                input logic [31:0] exp_rdata, input logic exp_opc,
                                output int waited, output logic rv_at_gnt, output logic derr_at_gnt);
    bit granted;
    granted     = 1'b0;
    waited      = 0;
    rv_at_gnt   = 1'b0;
    derr_at_gnt = 1'b0;
    m_req_i     = 1'b1;
    m_add_i     = addr;
    m_wen_i     = wen;
    m_wdata_i   = wdata;
    m_be_i      = be;
    for (int k = 0; k < 40 && !granted; k++) begin
      @(negedge clk_i);
      if (m_gnt_o) begin
        granted     = 1'b1;
        rv_at_gnt   = m_r_valid_o;
        derr_at_gnt = dec_err_o;
        check_output("s_req_onehot", 96'(s_req_o), 96'(exp_sreq));
        if (exp_sreq != 2'b00)
          check_output("s_payload", 96'({s_add_o, s_wen_o, s_wdata_o, s_be_o}),
                       96'({addr, wen, wdata, be}));
        exp_q.push_back('{rdata: exp_rdata, opc: exp_opc});
      end else begin
        waited++;
      end
    end
    if (!granted) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout: actual no grant after 40 cycles required grant addr=%0h", addr);
    end
    @(posedge clk_i);
    #1;
    m_req_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 60) begin
      @(negedge clk_i);
      k++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: actual %0d responses missing required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_stall(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      check_output(name, 96'({m_gnt_o, s_req_o}), 96'(0));
    end
  endtask

  initial begin
    int   w;
    logic rv;
    logic de;

    rst_i     = 1'b0;
    m_req_i   = 1'b0;
    m_add_i   = '0;
    m_wen_i   = 1'b1;
    m_wdata_i = '0;
    m_be_i    = 4'hF;
    #1;
    rst_i   = 1'b1;
    m_req_i = 1'b1;
    m_add_i = 32'h1C00_0000;
    @(negedge clk_i);
    check_output("rst_gnt", 96'(m_gnt_o), 96'(0));
    check_output("rst_s_req", 96'(s_req_o), 96'(0));
    check_output("rst_s_add", 96'(s_add_o), 96'(0));
    check_output("rst_flags", 96'({m_r_valid_o, dec_err_o, spurious_o}), 96'(0));
    check_output("rst_dec_err_addr", 96'(dec_err_addr_o), 96'(0));
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    m_req_i = 1'b0;

    // Single accesses to each slave, including region boundaries and one write.
    apply_stimulus(32'h1C00_0100, 1'b1, 32'h0, 4'hF, 2'b01, 32'h2C00_0100, 1'b0, w, rv, de);
    check_output("s0_read_wait", 96'(w), 96'(0));
    apply_stimulus(32'h1C00_0104, 1'b0, 32'hCAFE_F00D, 4'b0011, 2'b01, 32'h2C00_0104, 1'b0, w, rv, de);
    apply_stimulus(32'h1C00_7FFC, 1'b1, 32'h0, 4'hF, 2'b01, 32'h2C00_7FFC, 1'b0, w, rv, de);
    drain();
    apply_stimulus(32'h1C07_FFFC, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C07_FFFC, 1'b0, w, rv, de);
    check_output("s1_switch_wait", 96'(w), 96'(0));
    drain();

    // Burst to slave 1 with responses held: four grants, then the counter is full.
    hold = 2'b10;
    apply_stimulus(32'h1C01_0000, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C01_0000, 1'b0, w, rv, de);
    check_output("burst_wait0", 96'(w), 96'(0));
    apply_stimulus(32'h1C01_0004, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C01_0004, 1'b0, w, rv, de);
    check_output("burst_wait1", 96'(w), 96'(0));
    apply_stimulus(32'h1C01_0008, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C01_0008, 1'b1, w, rv, de);
    check_output("burst_wait2", 96'(w), 96'(0));
    apply_stimulus(32'h1C01_000C, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C01_000C, 1'b0, w, rv, de);
    check_output("burst_wait3", 96'(w), 96'(0));
    m_req_i = 1'b1;
    m_add_i = 32'h1C01_0010;
    expect_stall("full_stall", 3);
    hold = 2'b00;
    @(negedge clk_i);
    check_output("full_rsp_no_gnt", 96'({m_r_valid_o, m_gnt_o}), 96'(2'b10));
    hold = 2'b10;
    apply_stimulus(32'h1C01_0010, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C01_0010, 1'b0, w, rv, de);
    check_output("fifth_gnt_next_cycle", 96'(w), 96'(0));
    m_req_i = 1'b1;
    m_add_i = 32'h1C01_0014;
    expect_stall("refull_stall", 3);
    hold = 2'b00;
    apply_stimulus(32'h1C01_0014, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C01_0014, 1'b0, w, rv, de);
    check_output("sixth_gnt_wait", 96'(w), 96'(1));
    drain();

    // Target switch: slave 1 waits until both slave 0 responses have returned.
    hold = 2'b01;
    apply_stimulus(32'h1C00_0000, 1'b1, 32'h0, 4'hF, 2'b01, 32'h2C00_0000, 1'b0, w, rv, de);
    apply_stimulus(32'h1C00_0008, 1'b1, 32'h0, 4'hF, 2'b01, 32'h2C00_0008, 1'b1, w, rv, de);
    m_req_i = 1'b1;
    m_add_i = 32'h1C00_8000;
    expect_stall("switch_stall", 3);
    hold = 2'b00;
    apply_stimulus(32'h1C00_8000, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C00_8000, 1'b0, w, rv, de);
    check_output("switch_gnt_wait", 96'(w), 96'(2));
    drain();

    // Unmapped accesses answered locally one cycle after the grant.
    apply_stimulus(32'h0000_0010, 1'b1, 32'h0, 4'hF, 2'b00, 32'hBADA_CCE5, 1'b1, w, rv, de);
    check_output("err_gnt_wait", 96'(w), 96'(0));
    check_output("err_dec_pulse", 96'(de), 96'(1));
    @(negedge clk_i);
    check_output("err_rsp_next", 96'({m_r_valid_o, dec_err_o}), 96'(2'b10));
    check_output("err_addr", 96'(dec_err_addr_o), 96'(32'h0000_0010));
    drain();
    apply_stimulus(32'h1C08_0000, 1'b1, 32'h0, 4'hF, 2'b00, 32'hBADA_CCE5, 1'b1, w, rv, de);
    check_output("err_end_pulse", 96'(de), 96'(1));
    drain();
    check_output("err_end_addr", 96'(dec_err_addr_o), 96'(32'h1C08_0000));

    // Response from an idle slave is dropped and flagged.
    check_output("spur_before", 96'(spurious_o), 96'(0));
    spur_inj = 2'b10;
    @(posedge clk_i);
    @(negedge clk_i);
    check_output("spur_not_fwd", 96'(m_r_valid_o), 96'(0));
    @(posedge clk_i);
    spur_inj = 2'b00;
    @(negedge clk_i);
    check_output("spur_set", 96'(spurious_o), 96'(1));
    repeat (5) @(negedge clk_i);
    check_output("spur_sticky", 96'(spurious_o), 96'(1));
    @(posedge clk_i);
    #1;

    // Reset with three transactions in flight to slave 1.
    hold = 2'b10;
    apply_stimulus(32'h1C01_0100, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C01_0100, 1'b0, w, rv, de);
    apply_stimulus(32'h1C01_0104, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C01_0104, 1'b0, w, rv, de);
    apply_stimulus(32'h1C01_0108, 1'b1, 32'h0, 4'hF, 2'b10, 32'h3C01_0108, 1'b1, w, rv, de);
    m_req_i = 1'b1;
    m_add_i = 32'h1C01_010C;
    rst_i   = 1'b1;
    #1;
    check_output("inflight_rst_gnt_req", 96'({m_gnt_o, s_req_o, m_r_valid_o}), 96'(0));
    check_output("inflight_rst_s_add", 96'(s_add_o), 96'(0));
    check_output("inflight_rst_regs", 96'({dec_err_addr_o, spurious_o}), 96'(0));
    exp_q.delete();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    m_req_i = 1'b0;
    @(negedge clk_i);
    check_output("post_rst_spur", 96'(spurious_o), 96'(0));
    apply_stimulus(32'h1C00_0200, 1'b1, 32'h0, 4'hF, 2'b01, 32'h2C00_0200, 1'b0, w, rv, de);
    check_output("post_rst_gnt_wait", 96'(w), 96'(0));
    drain();
    hold = 2'b00;
    repeat (8) @(negedge clk_i);
    check_output("late_rsp_spur", 96'(spurious_o), 96'(1));
    check_output("sb_leftover", 96'(exp_q.size()), 96'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
